// File: rtl/spi_exe_pkg.sv
// Shared definitions for the execution unit's thermometer encode/decode path.
package spi_exe_pkg;

    localparam int M_DEF = 8;

    function automatic int cnt_w(input int m);
        return $clog2(m + 1);
    endfunction

    typedef struct packed {
        logic [M_DEF-1:0] a;
        logic             vf;
        logic             bubble;
    } thermo_result_t;

endpackage

// File: rtl/thermo_popcount.sv
// Combinational population count of a thermometer code plus a monotonicity check.
module thermo_popcount
    import spi_exe_pkg::*;
#(
    parameter int M = M_DEF
) (
    input  logic [M-1:0] code_i,
    output logic [M-1:0] cnt_o,
    output logic         mono_o
);

    localparam int CW = cnt_w(M);

    logic [CW-1:0] cnt;
    logic [M:0]    ext;
    logic [M:0]    ext_inc;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < M; i++) begin
            cnt = cnt + CW'(code_i[i]);
        end
    end

    // A valid code is 2^n-1; adding one clears every set bit only in that case.
    assign ext     = {1'b0, code_i};
    assign ext_inc = ext + (M+1)'(1);
    assign mono_o  = ((ext & ext_inc) == '0);
    assign cnt_o   = M'(cnt);

endmodule

// File: rtl/thermometer_decoder.sv
// Two-stage thermometer-to-binary decoder with valid/ready on both sides and a
// saturating bubble-error counter for the status path.
module thermometer_decoder
    import spi_exe_pkg::*;
#(
    parameter int M     = M_DEF,
    parameter int ERR_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [M-1:0]     i_thermo,
    input  logic             i_vf,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [M-1:0]     o_a,
    output logic             o_vf,
    output logic             o_bubble,
    input  logic             i_err_clr,
    output logic [ERR_W-1:0] o_err_cnt
);

    localparam logic [M-1:0] FULL_A = M'(M);

    logic             s1_valid_q, s1_valid_d;
    logic [M-1:0]     s1_code_q,  s1_code_d;
    logic             s1_vf_q,    s1_vf_d;
    logic             s2_valid_q, s2_valid_d;
    logic [M-1:0]     a_q,        a_d;
    logic             vf_q,       vf_d;
    logic             bubble_q,   bubble_d;
    logic [ERR_W-1:0] err_q,      err_d;

    logic         s2_load;
    logic         in_xfer;
    logic         out_xfer;
    logic [M-1:0] pc_cnt;
    logic         pc_mono;

    thermo_popcount #(.M(M)) u_popcount (
        .code_i (s1_code_q),
        .cnt_o  (pc_cnt),
        .mono_o (pc_mono)
    );

    always_comb begin
        s2_load  = s1_valid_q && (!s2_valid_q || i_ready);
        o_ready  = !s1_valid_q || s2_load;
        in_xfer  = i_valid && o_ready;
        out_xfer = s2_valid_q && i_ready;

        s1_valid_d = s1_valid_q;
        s1_code_d  = s1_code_q;
        s1_vf_d    = s1_vf_q;
        s2_valid_d = s2_valid_q;
        a_d        = a_q;
        vf_d       = vf_q;
        bubble_d   = bubble_q;
        err_d      = err_q;

        if (in_xfer) begin
            s1_valid_d = 1'b1;
            s1_code_d  = i_thermo;
            s1_vf_d    = i_vf;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        // Overflow forces full scale but the bubble flag still reflects the code.
        if (s2_load) begin
            s2_valid_d = 1'b1;
            a_d        = s1_vf_q ? FULL_A : pc_cnt;
            vf_d       = s1_vf_q;
            bubble_d   = !pc_mono;
        end else if (out_xfer) begin
            s2_valid_d = 1'b0;
        end

        if (i_err_clr) begin
            err_d = '0;
        end else if (out_xfer && bubble_q && (err_q != '1)) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_code_q  <= '0;
            s1_vf_q    <= 1'b0;
            s2_valid_q <= 1'b0;
            a_q        <= '0;
            vf_q       <= 1'b0;
            bubble_q   <= 1'b0;
            err_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_code_q  <= s1_code_d;
            s1_vf_q    <= s1_vf_d;
            s2_valid_q <= s2_valid_d;
            a_q        <= a_d;
            vf_q       <= vf_d;
            bubble_q   <= bubble_d;
            err_q      <= err_d;
        end
    end

    assign o_valid   = s2_valid_q;
    assign o_a       = a_q;
    assign o_vf      = vf_q;
    assign o_bubble  = bubble_q;
    assign o_err_cnt = err_q;

endmodule

// File: tb/tb_thermometer_decoder.sv
// Directed bench for thermometer_decoder; a second instance with a 2-bit error
// counter shares the stimulus to exercise saturation.
module tb_thermometer_decoder;
    import spi_exe_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       i_valid;
    logic [7:0] i_thermo;
    logic       i_vf;
    logic       i_ready;
    logic       i_err_clr;

    logic       o_ready, o_valid, o_vf, o_bubble;
    logic [7:0] o_a;
    logic [7:0] o_err_cnt;

    logic       o2_ready, o2_valid, o2_vf, o2_bubble;
    logic [7:0] o2_a;
    logic [1:0] o2_err_cnt;

    thermometer_decoder dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_thermo  (i_thermo),
        .i_vf      (i_vf),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_a       (o_a),
        .o_vf      (o_vf),
        .o_bubble  (o_bubble),
        .i_err_clr (i_err_clr),
        .o_err_cnt (o_err_cnt)
    );

    thermometer_decoder #(.ERR_W(2)) dut2 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o2_ready),
        .i_thermo  (i_thermo),
        .i_vf      (i_vf),
        .o_valid   (o2_valid),
        .i_ready   (i_ready),
        .o_a       (o2_a),
        .o_vf      (o2_vf),
        .o_bubble  (o2_bubble),
        .i_err_clr (i_err_clr),
        .o_err_cnt (o2_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int delivered = 0;
    thermo_result_t q[$];
    thermo_result_t drv_exp;
    thermo_result_t held;
    bit stall_prev = 0;
    bit last_ready = 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Samples at the falling edge, scores transfers and stalls, then advances one cycle.
    task automatic tick(output bit acc);
        thermo_result_t e;
        @(negedge clk);
        acc = i_valid && o_ready;
        last_ready = o_ready;
        if (stall_prev && o_valid) begin
            chk("hold_a", {24'b0, o_a}, {24'b0, held.a});
            chk("hold_vf", {31'b0, o_vf}, {31'b0, held.vf});
            chk("hold_bubble", {31'b0, o_bubble}, {31'b0, held.bubble});
        end
        if (o_valid && i_ready) begin
            chk("no_extra_result", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                delivered++;
                chk("out_a", {24'b0, o_a}, {24'b0, e.a});
                chk("out_vf", {31'b0, o_vf}, {31'b0, e.vf});
                chk("out_bubble", {31'b0, o_bubble}, {31'b0, e.bubble});
            end
        end
        stall_prev = o_valid && !i_ready;
        held = '{a: o_a, vf: o_vf, bubble: o_bubble};
        if (acc) q.push_back(drv_exp);
        @(posedge clk);
        #1;
    endtask

    task automatic t();
        bit a;
        tick(a);
    endtask

    task automatic drive(input logic [7:0] code, input logic vf, input logic [7:0] ea, input logic eb);
        i_valid  = 1'b1;
        i_thermo = code;
        i_vf     = vf;
        drv_exp  = '{a: ea, vf: vf, bubble: eb};
    endtask

    task automatic send1(input logic [7:0] code, input logic vf, input logic [7:0] ea, input logic eb);
        drive(code, vf, ea, eb);
        t();
        i_valid = 1'b0;
        repeat (3) t();
    endtask

    initial begin
        bit acc;
        int idx;
        int stall_acc;
        bit saw_low;
        int d0;
        logic [8:0] c9;
        logic [1:0] sat_exp [5];
        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

        rst_n = 1'b0; i_valid = 1'b0; i_thermo = '0; i_vf = 1'b0;
        i_ready = 1'b1; i_err_clr = 1'b0; drv_exp = '0;
        #8;
        chk("rst_o_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_o_a", {24'b0, o_a}, 32'd0);
        chk("rst_o_vf", {31'b0, o_vf}, 32'd0);
        chk("rst_o_bubble", {31'b0, o_bubble}, 32'd0);
        chk("rst_err_cnt", {24'b0, o_err_cnt}, 32'd0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", {31'b0, o_ready}, 32'd1);

        // back-to-back codes with latency checks
        drive(8'h00, 1'b0, 8'd0, 1'b0); t();
        chk("lat_c0_valid", {31'b0, o_valid}, 32'd0);
        drive(8'h07, 1'b0, 8'd3, 1'b0); t();
        chk("lat_c1_valid", {31'b0, o_valid}, 32'd1);
        chk("lat_c1_a", {24'b0, o_a}, 32'd0);
        drive(8'hFF, 1'b0, 8'd8, 1'b0); t();
        chk("lat_c2_a", {24'b0, o_a}, 32'd3);
        i_valid = 1'b0; t();
        chk("lat_c3_a", {24'b0, o_a}, 32'd8);
        chk("lat_c3_bubble", {31'b0, o_bubble}, 32'd0);
        repeat (2) t();
        chk("err_after_clean", {24'b0, o_err_cnt}, 32'd0);

        send1(8'h05, 1'b0, 8'd2, 1'b1);
        chk("err_after_bubble", {24'b0, o_err_cnt}, 32'd1);
        chk("err2_after_bubble", {30'b0, o2_err_cnt}, 32'd1);

        send1(8'h01, 1'b1, 8'd8, 1'b0);
        chk("err_after_vf", {24'b0, o_err_cnt}, 32'd1);

        // stream 0..8 with a three-cycle downstream stall
        idx = 0; stall_acc = 0; saw_low = 0; d0 = delivered;
        for (int cyc = 0; idx < 9 && cyc < 100; cyc++) begin
            i_ready = !(cyc >= 4 && cyc <= 6);
            c9 = (9'd1 << idx) - 9'd1;
            drive(c9[7:0], 1'b0, 8'(idx), 1'b0);
            tick(acc);
            if (!i_ready) begin
                if (!last_ready) saw_low = 1;
                if (acc) stall_acc++;
            end
            if (acc) idx++;
        end
        i_valid = 1'b0; i_ready = 1'b1;
        chk("stream_accepted", 32'(idx), 32'd9);
        chk("stall_ready_low", {31'b0, saw_low}, 32'd1);
        chk("stall_accepts_le2", 32'(stall_acc <= 2), 32'd1);
        for (int w = 0; w < 20 && q.size() != 0; w++) t();
        chk("stream_drained", 32'(q.size()), 32'd0);
        chk("stream_delivered", 32'(delivered - d0), 32'd9);

        // saturation on the 2-bit counter
        i_err_clr = 1'b1; t(); i_err_clr = 1'b0;
        chk("clr_err", {24'b0, o_err_cnt}, 32'd0);
        chk("clr_err2", {30'b0, o2_err_cnt}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            send1(8'h05, 1'b0, 8'd2, 1'b1);
            chk("sat_err2", {30'b0, o2_err_cnt}, {30'b0, sat_exp[k]});
            chk("sat_err", {24'b0, o_err_cnt}, 32'(k + 1));
        end

        // clear coinciding with a bubble output transfer
        drive(8'h0B, 1'b0, 8'd3, 1'b1); t();
        i_valid = 1'b0; t();
        chk("clr_coinc_valid", {31'b0, o_valid}, 32'd1);
        i_err_clr = 1'b1; t(); i_err_clr = 1'b0;
        chk("clr_coinc_err", {24'b0, o_err_cnt}, 32'd0);
        chk("clr_coinc_err2", {30'b0, o2_err_cnt}, 32'd0);
        t();
        chk("clr_coinc_hold", {24'b0, o_err_cnt}, 32'd0);

        // asynchronous reset with both stages full
        drive(8'h03, 1'b0, 8'd2, 1'b0); t();
        drive(8'h0F, 1'b0, 8'd4, 1'b0); t();
        chk("pre_rst_valid", {31'b0, o_valid}, 32'd1);
        i_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, o_valid}, 32'd0);
        chk("async_rst_a", {24'b0, o_a}, 32'd0);
        chk("async_rst_ready", {31'b0, o_ready}, 32'd1);
        q.delete();
        stall_prev = 0;
        #2 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            t();
            chk("no_stale_after_rst", {31'b0, o_valid}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/thermometer_decoder.md
Name: thermometer_decoder

Overview:
- Inverse of the execution unit's thermometer encoder: accepts an M-bit thermometer code plus overflow flag and returns the binary count.
- Two-stage registered pipeline with valid/ready handshakes on both sides.
- Detects non-monotonic ("bubble") codes and keeps a saturating bubble-error counter for the SPI status path.
- Sits between the thermometer-coded result bus and the binary result/status registers of the execution unit.

Parameters:
- M, 8, thermometer code width; also the width of the binary count output (the encoder's input width).
- ERR_W, 8, width of the saturating bubble-error counter.

Ports:
- i_clk  input  1  clock, all state on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  input code valid
- o_ready  output  1  decoder can accept input this cycle
- i_thermo  input  M  thermometer code; bit i set means count > i
- i_vf  input  1  overflow flag accompanying the code
- o_valid  output  1  output result valid
- i_ready  input  1  downstream accepts result
- o_a  output  M  decoded binary count, 0..M
- o_vf  output  1  overflow flag passed through
- o_bubble  output  1  code was not of form 2^n-1
- i_err_clr  input  1  synchronous clear of error counter
- o_err_cnt  output  ERR_W  saturating count of accepted bubble codes

Behaviour:
- Reset (async, i_rst_n=0): o_valid=0, o_a=0, o_vf=0, o_bubble=0, o_err_cnt=0, internal stage valids=0. o_ready=1 from the first cycle after reset release.
- Transfers:
  - Input transfer when i_valid && o_ready.
  - Output transfer when o_valid && i_ready.
  - Payload on o_a/o_vf/o_bubble is held stable while o_valid && !i_ready.
- Stage 1, on input transfer, registers:
  - i_thermo and i_vf.
  - monotonic = ((i_thermo & (i_thermo + 1)) == 0), computed in M+1 bits.
- Stage 2 registers:
  - o_a = popcount of stage-1 code, zero-extended to M bits.
  - o_bubble = !monotonic.
  - o_vf = stage-1 vf.
- Overflow handling: if vf=1, o_a is forced to M regardless of code, and o_bubble is still reported.
- Latency: 2 cycles from input transfer to o_valid with no backpressure. Throughput is 1 per cycle.
- Flow control:
  - s2 loads when s1 valid && (!o_valid || i_ready).
  - s1 loads on input transfer.
  - o_ready = !s1_valid || s2 loading. This is a combinational path from i_ready, which is accepted.
  - No bubbles are inserted when both ends are always ready.
  - Full backpressure holds both stages and drops o_ready, with no data loss or duplication.
- Error counter:
  - Increments by 1 on each output transfer with o_bubble=1.
  - Saturates at 2^ERR_W-1.
  - i_err_clr has priority: if a clear and an increment occur in the same cycle, the result is 0.
- Boundaries:
  - i_thermo=0 gives o_a=0, no bubble.
  - All ones gives o_a=M, no bubble.
  - A bubble code yields the popcount.
  - A reset mid-transfer discards both stages.

Decomposition:
- Shared package (spi_exe_pkg):
  - default M.
  - count width function: $clog2(M+1).
  - a result struct typedef {a, vf, bubble}, reused by the encoder testbench.
- Sub-module thermo_popcount:
  - combinational popcount plus monotonic check.
  - instantiated between stage 1 and stage 2.
- The pipeline, handshake and counter logic stay in the top module.

Test Plan:
- Reset, then send 8'b0000_0000, 8'b0000_0111, 8'b1111_1111 with vf=0 and i_ready=1 → o_a = 0, 3, 8 on consecutive cycles starting 2 cycles after the first input; o_bubble=0; o_err_cnt=0.
- Send 8'b0000_0101 → o_a=2, o_bubble=1, o_err_cnt=1.
- Send 8'b0000_0001 with vf=1 → o_a=8, o_vf=1, o_bubble=0.
- Stream 0..8 (as codes) with i_ready low for 3 cycles mid-stream → o_ready drops within 2 accepted beats; all 9 results arrive in order with no loss and no duplicates; the held payload is stable while stalled.
- With ERR_W=2, send 5 bubble codes → o_err_cnt = 1, 2, 3, 3, 3. Then pulse i_err_clr in the same cycle as a bubble output transfer → o_err_cnt=0.
- Assert i_rst_n=0 while both stages are valid → o_valid=0 immediately (asynchronous). After release, no stale results appear.
